imem_stream_loader: RTL



---
 rtl/imem_stream_loader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/imem_stream_loader.sv
// Packs a length-prefixed big-endian byte stream into instruction memory and holds the CPU until loaded.
// Latency: im_we pulses the cycle after a word's 4th byte; trailer checksum check only with IMEM_LOADER_CHECKSUM_EN.
// Backpressure: byte_ready depends only on state (high in HDR_HI/HDR_LO/DATA/CHK), sustains one byte per cycle.
module imem_stream_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        im_we,
   output logic [31:0] im_addr,
   output logic [31:0] im_wdata,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        load_error,
   output logic [15:0] words_loaded
);

   localparam logic [16:0] MAX_W17 = 17'(MAX_WORDS);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR_HI,
      ST_HDR_LO,
      ST_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK,
`endif
      ST_DONE
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  hdr_hi_q;
   logic [15:0] n_words;
   logic [23:0] asm_q;
   logic [1:0]  byte_idx;
   logic [15:0] n_hdr;
   logic        hdr_too_big;
   logic        last_byte_of_image;
   logic        start_ok;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   assign n_hdr              = {hdr_hi_q, byte_in};
   assign hdr_too_big        = ({1'b0, n_hdr} > MAX_W17);
   assign last_byte_of_image = (byte_idx == 2'd3) && ((words_loaded + 16'd1) == n_words);
   assign start_ok           = start && ((state == ST_IDLE) || (state == ST_DONE));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Handshake outputs are pure functions of state so byte_ready never waits on byte_valid.
   always_comb begin
      state_nxt  = state;
      byte_ready = 1'b0;
      load_done  = 1'b0;
      cpu_hold   = 1'b1;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_HDR_HI;
         end
         ST_HDR_HI: begin
            byte_ready = 1'b1;
            if (byte_valid) state_nxt = ST_HDR_LO;
         end
         ST_HDR_LO: begin
            byte_ready = 1'b1;
            if (byte_valid) begin
               if ((n_hdr == 16'd0) || hdr_too_big) state_nxt = ST_DONE;
               else                                 state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            byte_ready = 1'b1;
            if (byte_valid && last_byte_of_image) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_nxt = ST_CHK;
`else
               state_nxt = ST_DONE;
`endif
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CHK: begin
            byte_ready = 1'b1;
            if (byte_valid) state_nxt = ST_DONE;
         end
`endif
         ST_DONE: begin
            load_done = 1'b1;
            cpu_hold  = 1'b0;
            if (start) state_nxt = ST_HDR_HI;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         im_we        <= 1'b0;
         im_addr      <= BASE_ADDR;
         im_wdata     <= 32'h0;
         load_error   <= 1'b0;
         words_loaded <= 16'd0;
         hdr_hi_q     <= 8'h0;
         n_words      <= 16'd0;
         asm_q        <= 24'h0;
         byte_idx     <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum         <= 8'h0;
`endif
      end else begin
         im_we <= 1'b0;
         if (start_ok) begin
            load_error   <= 1'b0;
            words_loaded <= 16'd0;
            byte_idx     <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= 8'h0;
`endif
         end
         case (state)
            ST_HDR_HI: begin
               if (byte_valid) hdr_hi_q <= byte_in;
            end
            ST_HDR_LO: begin
               if (byte_valid) begin
                  n_words <= n_hdr;
                  if (hdr_too_big) load_error <= 1'b1;
               end
            end
            ST_DATA: begin
               if (byte_valid) begin
                  byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum     <= csum ^ byte_in;
`endif
                  // im_wdata is a separate register, so the assembler can take the next byte during the write.
                  if (byte_idx == 2'd3) begin
                     im_we        <= 1'b1;
                     im_wdata     <= {asm_q, byte_in};
                     im_addr      <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
                     words_loaded <= words_loaded + 16'd1;
                  end else begin
                     asm_q <= {asm_q[15:0], byte_in};
                  end
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
               if (byte_valid && (byte_in != csum)) load_error <= 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   a_we_single: assert property (@(posedge clk) disable iff (reset) im_we |=> !im_we);
   a_wl_bound:  assert property (@(posedge clk) disable iff (reset) ({1'b0, words_loaded} <= MAX_W17));

endmodule
